// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: serializer states,
// frame constants and the baud divider computation.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Integer division; the remainder is deliberately dropped.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with extra-wrap-bit pointers; the head byte is presented
// combinationally from storage so the reader can take it in the pop cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        push;
  logic        pop;

  // Writes are refused while full, even if a pop happens on the same edge.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = LW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding an 8N1 serializer with an internal
// baud divider. uart_tx is registered from the FSM state, one cycle behind it.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BAUD         = 115200,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       busy,
  output logic                       uart_tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = 1;
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] BIT_ONE   = 1;

  tx_state_t     state;
  tx_state_t     state_d;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_d;
  logic [IW-1:0] bit_idx;
  logic [IW-1:0] bit_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          rd_en;
  logic [7:0]    rd_data;

  // Handshake: wr_en is valid and !full is ready; a byte moves on every edge
  // where both hold. The serializer raises rd_en only while !empty, and
  // takes rd_data in that same cycle.
  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    rd_en   = 1'b0;
    tx_d    = 1'b1;
    case (state)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          rd_en   = 1'b1;
          shift_d = rd_data;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        tx_d = shift[0];
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == BIT_LAST) state_d = STOP;
          else bit_d = bit_idx + BIT_ONE;
        end else begin
          baud_d = baud_cnt + BAUD_ONE;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_d = '0;
          bit_d  = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!empty) begin
            rd_en   = 1'b1;
            shift_d = rd_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast instance (4 clocks/bit, 4 entries) and a
// default-parameter instance, each with a line decoder feeding a scoreboard.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_wr_en, a_full, a_empty, a_overflow, a_busy, a_tx;
  logic [7:0] a_wr_data;
  logic [2:0] a_level;
  logic       b_rst_n, b_wr_en, b_full, b_empty, b_overflow, b_busy, b_tx;
  logic [7:0] b_wr_data;
  logic [4:0] b_level;

  uart_tx_fifo #(.DEPTH(4), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .full(a_full), .empty(a_empty), .level(a_level), .overflow(a_overflow),
    .busy(a_busy), .uart_tx(a_tx)
  );

  uart_tx_fifo dut_b (
    .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full(b_full), .empty(b_empty), .level(b_level), .overflow(b_overflow),
    .busy(b_busy), .uart_tx(b_tx)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [1:0] mon_en;

  // 0x41 on the line, time order from bit 0: start, 1,0,0,0,0,0,1,0, stop.
  logic [9:0]  pat_41 = 10'b10_1000_0010;
  logic [39:0] cap, exp_wave;
  logic [7:0]  bb[3]   = '{8'h72, 8'h65, 8'h67};
  int          lv_b2b[3] = '{1, 1, 2};
  logic [7:0]  ob[6]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int          lv_ov[6]  = '{1, 1, 2, 3, 4, 4};
  int          busy_cnt, low_cnt, sent, cyc, g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int which);
    return (which == 0) ? a_tx : b_tx;
  endfunction

  // Called on the first negedge the line is seen low; samples mid-bit.
  task automatic decode_frame(input int which, input int cpb,
                              output logic [7:0] d, output logic ok);
    logic start_ok;
    repeat (cpb / 2) @(negedge clk);
    start_ok = (tx_of(which) == 1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (cpb) @(negedge clk);
      d[b] = tx_of(which);
    end
    repeat (cpb) @(negedge clk);
    ok = start_ok && (tx_of(which) == 1'b1);
  endtask

  task automatic check_frame(input int which, input logic [7:0] d, input logic ok);
    logic [7:0] e;
    chk(which == 0 ? "frame_a_framing" : "frame_b_framing", ok, 1);
    if (which == 0 && exp_a.size() == 0 || which == 1 && exp_b.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_frame_%0d: actual %02h required no frame", which, d);
    end else begin
      e = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
      chk(which == 0 ? "frame_a_data" : "frame_b_data", d, e);
    end
  endtask

  initial begin : mon_a
    logic [7:0] d;
    logic ok;
    forever begin
      @(negedge clk);
      if (mon_en[0] && a_tx === 1'b0) begin
        decode_frame(0, 4, d, ok);
        check_frame(0, d, ok);
      end
    end
  end

  initial begin : mon_b
    logic [7:0] d;
    logic ok;
    forever begin
      @(negedge clk);
      if (mon_en[1] && b_tx === 1'b0) begin
        decode_frame(1, 234, d, ok);
        check_frame(1, d, ok);
      end
    end
  end

  task automatic wait_idle(input int which, input int budget);
    int c = 0;
    while (c < budget && !((which == 0) ? (!a_busy && a_empty) : (!b_busy && b_empty))) begin
      @(negedge clk);
      c++;
    end
    chk(which == 0 ? "idle_a_in_budget" : "idle_b_in_budget", c < budget, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    a_rst_n = 1'b0; a_wr_en = 1'b0; a_wr_data = '0;
    b_rst_n = 1'b0; b_wr_en = 1'b0; b_wr_data = '0;
    mon_en  = 2'b01;
    repeat (3) @(negedge clk);
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_level", a_level, 0);
    chk("rst_overflow", a_overflow, 0);
    a_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame of 0x41: exact waveform and busy length.
    @(negedge clk); a_wr_en = 1'b1; a_wr_data = 8'h41; exp_a.push_back(8'h41);
    @(negedge clk); a_wr_en = 1'b0;
    chk("p1_tx_after_push", a_tx, 1);
    chk("p1_empty_after_push", a_empty, 0);
    chk("p1_level_after_push", a_level, 1);
    @(negedge clk);
    chk("p1_busy_after_pop", a_busy, 1);
    chk("p1_empty_after_pop", a_empty, 1);
    chk("p1_tx_before_start", a_tx, 1);
    busy_cnt = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_busy) busy_cnt++;
      if (i < 40) cap[i] = a_tx;
    end
    for (int i = 0; i < 40; i++) exp_wave[i] = pat_41[i / 4];
    chk("p1_waveform", cap, exp_wave);
    chk("p1_busy_cycles", busy_cnt, 40);
    wait_idle(0, 100);

    // Back-to-back frames, no idle gap.
    @(negedge clk); a_wr_en = 1'b1; a_wr_data = bb[0]; exp_a.push_back(bb[0]);
    busy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("p2_level", a_level, lv_b2b[k]);
      if (a_busy) busy_cnt++;
      if (k < 2) begin
        a_wr_data = bb[k+1];
        exp_a.push_back(bb[k+1]);
      end else begin
        a_wr_en = 1'b0;
      end
    end
    g = 0;
    while (g < 400) begin
      @(negedge clk);
      if (!a_busy) break;
      busy_cnt++;
      g++;
    end
    chk("p2_busy_cycles", busy_cnt, 120);
    chk("p2_level_end", a_level, 0);
    wait_idle(0, 100);
    chk("p2_drained", exp_a.size(), 0);

    // Pointer wrap: 20 bytes, pushing only while not full.
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 2000) begin
      @(negedge clk);
      if (!a_full) begin
        a_wr_en = 1'b1;
        a_wr_data = 8'(sent);
        exp_a.push_back(8'(sent));
        sent++;
      end else begin
        a_wr_en = 1'b0;
      end
      cyc++;
    end
    @(negedge clk); a_wr_en = 1'b0;
    chk("p3_all_pushed", sent, 20);
    wait_idle(0, 1500);
    chk("p3_drained", exp_a.size(), 0);
    chk("p3_no_overflow", a_overflow, 0);

    // Overflow: six consecutive pushes, first is popped, sixth dropped.
    @(negedge clk); a_wr_en = 1'b1; a_wr_data = ob[0]; exp_a.push_back(ob[0]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("p4_level", a_level, lv_ov[k]);
      chk("p4_full", a_full, (k >= 4));
      chk("p4_overflow", a_overflow, (k == 5));
      if (k < 5) begin
        a_wr_data = ob[k+1];
        if (k < 4) exp_a.push_back(ob[k+1]);
      end else begin
        a_wr_en = 1'b0;
      end
    end
    wait_idle(0, 600);
    chk("p4_drained", exp_a.size(), 0);
    chk("p4_overflow_sticky", a_overflow, 1);

    // Reset during DATA bit 3 of 0x55 with two bytes queued.
    mon_en[0] = 1'b0;
    @(negedge clk); a_wr_en = 1'b1; a_wr_data = 8'h55;
    @(negedge clk); a_wr_data = 8'hAA;
    @(negedge clk); a_wr_data = 8'hBB;
    @(negedge clk); a_wr_en = 1'b0;
    chk("p5_level_queued", a_level, 2);
    repeat (16) @(negedge clk);
    chk("p5_busy_before_rst", a_busy, 1);
    a_rst_n = 1'b0;
    @(negedge clk);
    chk("p5_tx", a_tx, 1);
    chk("p5_busy", a_busy, 0);
    chk("p5_empty", a_empty, 1);
    chk("p5_level", a_level, 0);
    chk("p5_overflow", a_overflow, 0);
    a_rst_n = 1'b1;
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (!a_tx) low_cnt++;
      if (a_busy) busy_cnt++;
    end
    chk("p5_no_tx_after", low_cnt, 0);
    chk("p5_no_busy_after", busy_cnt, 0);

    // Default parameters: 234-cycle bit period, "\r\n".
    b_rst_n = 1'b1;
    mon_en[1] = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk); b_wr_en = 1'b1; b_wr_data = 8'h0D; exp_b.push_back(8'h0D);
    @(negedge clk); b_wr_data = 8'h0A; exp_b.push_back(8'h0A);
    @(negedge clk); b_wr_en = 1'b0;
    g = 0;
    while (b_tx !== 1'b0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("p6_start_seen", g < 20, 1);
    low_cnt = 0;
    while (b_tx === 1'b0 && low_cnt < 1000) begin
      low_cnt++;
      @(negedge clk);
    end
    chk("p6_bit_period", low_cnt, 234);
    wait_idle(1, 6000);
    chk("p6_drained", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
